// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC selection for the fetch stage.
// Chooses one redirect source per cycle (exception, branch, interrupt,
// return-from-trap, jump, stall, sequential), drives the pipeline flushes
// and keeps the trap return address and handler-mode flag.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        exception,
    input  logic [31:0] exc_pc,
    input  logic        irq,
    input  logic        eret,
    output logic [31:0] PC,
    output logic        flush_IF,
    output logic        flush_ID,
    output logic [31:0] epc,
    output logic        in_trap
);

    typedef enum logic [2:0] {
        SRC_EXC    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_IRQ    = 3'd2,
        SRC_ERET   = 3'd3,
        SRC_JUMP   = 3'd4,
        SRC_STALL  = 3'd5,
        SRC_SEQ    = 3'd6
    } src_t;

    logic [31:0] r_pc;
    logic [31:0] r_epc;
    logic        r_in_trap;
    logic        r_irq_pending;
    logic        w_irq_take;
    src_t        w_src;

    // Interrupts are blocked inside a handler and while fetching from the
    // upper half of the address space (where the handlers live).
    assign w_irq_take = (irq | r_irq_pending) & ~r_in_trap & ~r_pc[31];

    // Priority selection of this cycle's redirect source; jump and eret
    // are decoded in ID and therefore lose to a load-use stall.
    always_comb begin
        w_src = SRC_SEQ;
        if (exception)           w_src = SRC_EXC;
        else if (branch_taken)   w_src = SRC_BRANCH;
        else if (w_irq_take)     w_src = SRC_IRQ;
        else if (eret && !stall) w_src = SRC_ERET;
        else if (jump && !stall) w_src = SRC_JUMP;
        else if (stall)          w_src = SRC_STALL;
    end

    // Flushes are valid only in the redirect cycle and forced low in reset.
    always_comb begin
        flush_IF = 1'b0;
        flush_ID = 1'b0;
        if (reset) begin
            unique case (w_src)
                SRC_EXC, SRC_BRANCH: begin
                    flush_IF = 1'b1;
                    flush_ID = 1'b1;
                end
                SRC_IRQ, SRC_ERET, SRC_JUMP: flush_IF = 1'b1;
                SRC_STALL:                   flush_ID = 1'b1;
                default: ;
            endcase
        end
    end

    // PC / trap state update; a redirect in flight when reset hits is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_epc         <= 32'h0;
            r_in_trap     <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            if (w_src == SRC_IRQ)
                r_irq_pending <= 1'b0;
            else if (irq)
                r_irq_pending <= 1'b1;

            unique case (w_src)
                SRC_EXC: begin
                    r_pc      <= EXC_VECTOR;
                    r_epc     <= exc_pc;
                    r_in_trap <= 1'b1;
                end
                SRC_BRANCH: r_pc <= branch_target;
                SRC_IRQ: begin
                    r_pc      <= IRQ_VECTOR;
                    r_epc     <= r_pc;
                    r_in_trap <= 1'b1;
                end
                SRC_ERET: begin
                    r_pc      <= r_epc;
                    r_in_trap <= 1'b0;
                end
                SRC_JUMP:  r_pc <= jump_target;
                SRC_STALL: r_pc <= r_pc;
                default:   r_pc <= r_pc + 32'd4;
            endcase
        end
    end

    assign PC      = r_pc;
    assign epc     = r_epc;
    assign in_trap = r_in_trap;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus a randomized run
// checked against a table-driven next-PC model.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        exception;
    logic [31:0] exc_pc;
    logic        irq;
    logic        eret;
    logic [31:0] PC;
    logic        flush_IF;
    logic        flush_ID;
    logic [31:0] epc;
    logic        in_trap;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .RESET_PC  (RESET_PC),
        .IRQ_VECTOR(IRQ_VECTOR),
        .EXC_VECTOR(EXC_VECTOR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .exception    (exception),
        .exc_pc       (exc_pc),
        .irq          (irq),
        .eret         (eret),
        .PC           (PC),
        .flush_IF     (flush_IF),
        .flush_ID     (flush_ID),
        .epc          (epc),
        .in_trap      (in_trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        stall = 0; jump = 0; jump_target = 0; branch_taken = 0; branch_target = 0;
        exception = 0; exc_pc = 0; irq = 0; eret = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [31:0] a);
        jump = 1; jump_target = a;
        tick();
        idle();
    endtask

    task automatic test_reset();
        reset = 0; idle();
        #3;
        jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300;
        #1;
        checks++; if (PC !== RESET_PC) begin errors++; $display("FAIL rst_pc: PC=%h expected %h", PC, RESET_PC); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL rst_epc: epc=%h expected 0", epc); end
        checks++; if (in_trap !== 1'b0) begin errors++; $display("FAIL rst_in_trap: got %b expected 0", in_trap); end
        checks++; if (flush_IF !== 1'b0 || flush_ID !== 1'b0) begin errors++; $display("FAIL rst_flush: IF=%b ID=%b expected 0 0", flush_IF, flush_ID); end
        tick(); idle(); reset = 1;
        tick(); tick();
        checks++; if (PC !== 32'h8) begin errors++; $display("FAIL run_pc: PC=%h expected 8", PC); end
        // asynchronous reset in the middle of a redirect cycle
        jump = 1; jump_target = 32'h200;
        #2;
        checks++; if (flush_IF !== 1'b1) begin errors++; $display("FAIL pre_rst_flush: IF=%b expected 1", flush_IF); end
        reset = 0;
        #1;
        checks++; if (PC !== RESET_PC) begin errors++; $display("FAIL async_rst_pc: PC=%h expected %h", PC, RESET_PC); end
        checks++; if (flush_IF !== 1'b0) begin errors++; $display("FAIL async_rst_flush: IF=%b expected 0", flush_IF); end
        tick();
        checks++; if (PC !== RESET_PC) begin errors++; $display("FAIL rst_hold_pc: PC=%h expected %h", PC, RESET_PC); end
        idle(); reset = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (PC !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d: PC=%h expected %h", i, PC, 32'(4 * i)); end
        end
    endtask

    task automatic test_stall();
        jump_to(32'h10);
        checks++; if (PC !== 32'h10) begin errors++; $display("FAIL jump_pc: PC=%h expected 10", PC); end
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (flush_IF !== 1'b0 || flush_ID !== 1'b1) begin errors++; $display("FAIL stall_flush%0d: IF=%b ID=%b expected 0 1", i, flush_IF, flush_ID); end
            tick();
            checks++; if (PC !== 32'h10) begin errors++; $display("FAIL stall_pc%0d: PC=%h expected 10", i, PC); end
        end
        stall = 0;
        tick();
        checks++; if (PC !== 32'h14) begin errors++; $display("FAIL after_stall_pc: PC=%h expected 14", PC); end
        // eret and jump are ignored under a stall
        stall = 1; eret = 1; jump = 1; jump_target = 32'h500;
        #1;
        checks++; if (flush_IF !== 1'b0 || flush_ID !== 1'b1) begin errors++; $display("FAIL stall_eret_flush: IF=%b ID=%b expected 0 1", flush_IF, flush_ID); end
        tick(); idle();
        checks++; if (PC !== 32'h14) begin errors++; $display("FAIL stall_eret_pc: PC=%h expected 14", PC); end
    endtask

    task automatic test_priority();
        jump_to(32'h20);
        stall = 1; jump = 1; jump_target = 32'h100; branch_taken = 1; branch_target = 32'h40;
        #1;
        checks++; if (flush_IF !== 1'b1 || flush_ID !== 1'b1) begin errors++; $display("FAIL prio_flush: IF=%b ID=%b expected 1 1", flush_IF, flush_ID); end
        tick(); idle();
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL prio_pc: PC=%h expected 40", PC); end
    endtask

    task automatic test_irq_eret();
        jump_to(32'h30);
        irq = 1;
        #1;
        checks++; if (flush_IF !== 1'b1 || flush_ID !== 1'b0) begin errors++; $display("FAIL irq_flush: IF=%b ID=%b expected 1 0", flush_IF, flush_ID); end
        tick(); idle();
        checks++; if (PC !== IRQ_VECTOR) begin errors++; $display("FAIL irq_pc: PC=%h expected %h", PC, IRQ_VECTOR); end
        checks++; if (epc !== 32'h30) begin errors++; $display("FAIL irq_epc: epc=%h expected 30", epc); end
        checks++; if (in_trap !== 1'b1) begin errors++; $display("FAIL irq_in_trap: got %b expected 1", in_trap); end
        tick();
        eret = 1;
        #1;
        checks++; if (flush_IF !== 1'b1 || flush_ID !== 1'b0) begin errors++; $display("FAIL eret_flush: IF=%b ID=%b expected 1 0", flush_IF, flush_ID); end
        tick(); idle();
        checks++; if (PC !== 32'h30) begin errors++; $display("FAIL eret_pc: PC=%h expected 30", PC); end
        checks++; if (in_trap !== 1'b0) begin errors++; $display("FAIL eret_in_trap: got %b expected 0", in_trap); end
        checks++; if (epc !== 32'h30) begin errors++; $display("FAIL eret_epc: epc=%h expected 30", epc); end
    endtask

    task automatic test_nested_irq();
        irq = 1; tick(); idle();
        irq = 1;
        #1;
        checks++; if (flush_IF !== 1'b0 || flush_ID !== 1'b0) begin errors++; $display("FAIL nest_flush: IF=%b ID=%b expected 0 0", flush_IF, flush_ID); end
        tick(); idle();
        checks++; if (PC !== 32'h8000_0008) begin errors++; $display("FAIL nest_pc: PC=%h expected 80000008", PC); end
        checks++; if (dut.r_irq_pending !== 1'b1) begin errors++; $display("FAIL nest_pending: got %b expected 1", dut.r_irq_pending); end
        eret = 1; tick(); idle();
        checks++; if (PC !== 32'h30 || in_trap !== 1'b0) begin errors++; $display("FAIL nest_eret: PC=%h in_trap=%b expected 30 0", PC, in_trap); end
        #1;
        checks++; if (flush_IF !== 1'b1 || flush_ID !== 1'b0) begin errors++; $display("FAIL pend_flush: IF=%b ID=%b expected 1 0", flush_IF, flush_ID); end
        tick();
        checks++; if (PC !== IRQ_VECTOR || epc !== 32'h30) begin errors++; $display("FAIL pend_take: PC=%h epc=%h expected %h 30", PC, epc, IRQ_VECTOR); end
        checks++; if (dut.r_irq_pending !== 1'b0) begin errors++; $display("FAIL pend_clear: got %b expected 0", dut.r_irq_pending); end
        eret = 1; tick(); idle();
    endtask

    task automatic test_exception();
        exception = 1; exc_pc = 32'h24; irq = 1;
        #1;
        checks++; if (flush_IF !== 1'b1 || flush_ID !== 1'b1) begin errors++; $display("FAIL exc_flush: IF=%b ID=%b expected 1 1", flush_IF, flush_ID); end
        tick(); idle();
        checks++; if (PC !== EXC_VECTOR || epc !== 32'h24) begin errors++; $display("FAIL exc_state: PC=%h epc=%h expected %h 24", PC, epc, EXC_VECTOR); end
        checks++; if (in_trap !== 1'b1 || dut.r_irq_pending !== 1'b1) begin errors++; $display("FAIL exc_flags: in_trap=%b pending=%b expected 1 1", in_trap, dut.r_irq_pending); end
        exception = 1; exc_pc = 32'h55; stall = 1;
        tick(); idle();
        checks++; if (PC !== EXC_VECTOR || epc !== 32'h55) begin errors++; $display("FAIL exc_nested: PC=%h epc=%h expected %h 55", PC, epc, EXC_VECTOR); end
        eret = 1; tick(); idle();
        checks++; if (PC !== 32'h55 || in_trap !== 1'b0) begin errors++; $display("FAIL exc_eret: PC=%h in_trap=%b expected 55 0", PC, in_trap); end
        tick();
        checks++; if (PC !== IRQ_VECTOR || epc !== 32'h55) begin errors++; $display("FAIL exc_pend_take: PC=%h epc=%h expected %h 55", PC, epc, IRQ_VECTOR); end
        eret = 1; tick(); idle();
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC);
        irq = 1;
        #1;
        checks++; if (flush_IF !== 1'b0) begin errors++; $display("FAIL wrap_irq_block: IF=%b expected 0", flush_IF); end
        tick(); idle();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc: PC=%h expected 0", PC); end
        tick();
        checks++; if (PC !== IRQ_VECTOR || epc !== 32'h0) begin errors++; $display("FAIL wrap_pend_take: PC=%h epc=%h expected %h 0", PC, epc, IRQ_VECTOR); end
        eret = 1; tick(); idle();
    endtask

    task automatic test_random();
        logic [31:0] m_pc, m_epc;
        logic        m_trap, m_pend;
        logic [31:0] tgt [7];
        logic [6:0]  req;
        bit   [0:6]  fif_tab, fid_tab;
        int          win;
        fif_tab = 7'b1111100;
        fid_tab = 7'b1100010;
        reset = 0; idle(); tick(); reset = 1;
        m_pc = RESET_PC; m_epc = 0; m_trap = 0; m_pend = 0;
        for (int n = 0; n < 600; n++) begin
            stall         = ($urandom_range(4) == 0);
            jump          = ($urandom_range(5) == 0);
            jump_target   = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h7FFF_FFFF);
            branch_taken  = ($urandom_range(7) == 0);
            branch_target = $urandom & 32'h7FFF_FFFF;
            exception     = ($urandom_range(15) == 0);
            exc_pc        = $urandom;
            irq           = ($urandom_range(5) == 0);
            eret          = ($urandom_range(4) == 0);
            #1;
            req[0] = exception;
            req[1] = branch_taken;
            req[2] = (irq | m_pend) & !m_trap & !m_pc[31];
            req[3] = eret & !stall;
            req[4] = jump & !stall;
            req[5] = stall;
            req[6] = 1'b1;
            win = 6;
            for (int i = 5; i >= 0; i--) if (req[i]) win = i;
            tgt = '{EXC_VECTOR, branch_target, IRQ_VECTOR, m_epc, jump_target, m_pc, m_pc + 32'd4};
            checks++; if (flush_IF !== fif_tab[win] || flush_ID !== fid_tab[win]) begin errors++; $display("FAIL rnd_flush[%0d]: IF=%b ID=%b expected %b %b", n, flush_IF, flush_ID, fif_tab[win], fid_tab[win]); end
            tick();
            if (win == 0) m_epc = exc_pc;
            else if (win == 2) m_epc = m_pc;
            if (win == 0 || win == 2) m_trap = 1;
            else if (win == 3) m_trap = 0;
            if (win == 2) m_pend = 0;
            else if (irq) m_pend = 1;
            m_pc = tgt[win];
            checks++; if (PC !== m_pc || epc !== m_epc) begin errors++; $display("FAIL rnd_pc[%0d]: PC=%h epc=%h expected %h %h", n, PC, epc, m_pc, m_epc); end
            checks++; if (in_trap !== m_trap || dut.r_irq_pending !== m_pend) begin errors++; $display("FAIL rnd_flags[%0d]: in_trap=%b pending=%b expected %b %b", n, in_trap, dut.r_irq_pending, m_trap, m_pend); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stall();
        test_priority();
        test_irq_eret();
        test_nested_irq();
        test_exception();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
